ccl_scan_sequencer: RTL and testbench

Controller that sequences the connected-components frame-buffer datapath. It captures one masked frame into the 1-bit frame-buffer RAMs, then raster-scans the stored frame. For each pixel it issues the centre, W, NW, N and NE read addresses, waits out the RAM read latency, and presents a boundary-corrected 5-pixel window to the labeling unit under a valid/ready handshake. It sits between the mask pipeline (pixel stream in) and the first-pass labeler (window out). It owns every frame-buffer address and write enable.

---
 rtl/ccl_scan_sequencer_if.sv | 36 +++
 rtl/ccl_scan_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ccl_scan_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccl_scan_sequencer_if.sv
// Window bus between the scan sequencer and the first-pass labeler.
//
// Handshake: the sequencer raises win_valid_out with win_mask_out/win_x_out/
// win_y_out stable; the window is consumed in the cycle where both
// win_valid_out and win_ready_in are high. Once valid is raised, the window
// fields hold until that accept (or an abort/reset).
//
// Signals:
//   win_valid_out  window valid (sequencer -> labeler)
//   win_ready_in   labeler accepts window (labeler -> sequencer)
//   win_mask_out   {ne,n,nw,w,c}, out-of-frame neighbours forced 0
//   win_x_out      centre column
//   win_y_out      centre row
interface ccl_scan_sequencer_if;
  logic        win_valid_out;
  logic        win_ready_in;
  logic [4:0]  win_mask_out;
  logic [10:0] win_x_out;
  logic [9:0]  win_y_out;

  modport master (
    output win_valid_out,
    output win_mask_out,
    output win_x_out,
    output win_y_out,
    input  win_ready_in
  );

  modport slave (
    input  win_valid_out,
    input  win_mask_out,
    input  win_x_out,
    input  win_y_out,
    output win_ready_in
  );
endinterface

// File: rtl/ccl_scan_sequencer.sv
// Connected-components frame-buffer sequencer.
//
// Captures one masked frame into the 1-bit frame-buffer RAMs, then
// raster-scans it: per pixel it issues the centre/W/NW/N/NE read addresses,
// waits out the RAM read latency and presents a boundary-corrected 5-pixel
// window on the window bus.
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   new_frame_in            start capture (only looked at in IDLE)
//   abort_in                synchronous abort back to IDLE
//   x_in, y_in, mask_in,
//   valid_in                incoming pixel stream
//   wr_en_out, wr_addr_out,
//   wr_data_out             frame-buffer write port (combinational)
//   rd_addr_*_out           frame-buffer read addresses
//   rd_data_in              read data {ne,n,nw,w,c}
//   win                     window bus (master side)
//   busy_out                high in every state except IDLE
//   done_out                one-cycle pulse after the final window accept
//   dbg_state               current FSM state for observation
module ccl_scan_sequencer #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 180,
  parameter int RAM_LATENCY = 2,
  parameter int ADDR_W      = $clog2(WIDTH*HEIGHT)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              new_frame_in,
  input  logic              abort_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic              mask_in,
  input  logic              valid_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic              wr_data_out,
  output logic [ADDR_W-1:0] rd_addr_c_out,
  output logic [ADDR_W-1:0] rd_addr_w_out,
  output logic [ADDR_W-1:0] rd_addr_nw_out,
  output logic [ADDR_W-1:0] rd_addr_n_out,
  output logic [ADDR_W-1:0] rd_addr_ne_out,
  input  logic [4:0]        rd_data_in,
  ccl_scan_sequencer_if.master win,
  output logic              busy_out,
  output logic              done_out,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RAM_LATENCY - 1);
  localparam logic [10:0]       X_LAST   = 11'(WIDTH - 1);
  localparam logic [9:0]        Y_LAST   = 10'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  state_t            state;
  logic [10:0]       scan_x;
  logic [9:0]        scan_y;
  logic [CNT_W-1:0]  wait_cnt;
  logic              win_valid;
  logic [4:0]        win_mask;
  logic [10:0]       win_x;
  logic [9:0]        win_y;

  logic              pix_write;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] scan_c;
  logic [4:0]        nb_ok;
  logic              scan_last;

  // Write path: zero latency, and abort suppresses a write in the same cycle.
  assign pix_write   = (state == S_CAPTURE) && valid_in && !abort_in &&
                       (x_in <= X_LAST) && (y_in <= Y_LAST);
  assign pix_addr    = ADDR_W'(y_in) * W_A + ADDR_W'(x_in);
  assign wr_en_out   = pix_write;
  assign wr_addr_out = pix_write ? pix_addr : '0;
  assign wr_data_out = pix_write & mask_in;

  // Neighbour validity {ne,n,nw,w,c}; the scan position is held through
  // ISSUE and WAIT, so these flags are valid in both.
  assign scan_c = ADDR_W'(scan_y) * W_A + ADDR_W'(scan_x);
  assign nb_ok  = {(scan_y != '0) && (scan_x != X_LAST),
                   (scan_y != '0),
                   (scan_y != '0) && (scan_x != '0),
                   (scan_x != '0),
                   1'b1};
  assign scan_last = (scan_x == X_LAST) && (scan_y == Y_LAST);

  assign win.win_valid_out = win_valid;
  assign win.win_mask_out  = win_mask;
  assign win.win_x_out     = win_x;
  assign win.win_y_out     = win_y;
  assign dbg_state         = state;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= S_IDLE;
      scan_x         <= '0;
      scan_y         <= '0;
      wait_cnt       <= '0;
      rd_addr_c_out  <= '0;
      rd_addr_w_out  <= '0;
      rd_addr_nw_out <= '0;
      rd_addr_n_out  <= '0;
      rd_addr_ne_out <= '0;
      win_valid      <= 1'b0;
      win_mask       <= '0;
      win_x          <= '0;
      win_y          <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (abort_in) begin
        state     <= S_IDLE;
        win_valid <= 1'b0;
        busy_out  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            scan_x <= '0;
            scan_y <= '0;
            if (new_frame_in) begin
              state    <= S_CAPTURE;
              busy_out <= 1'b1;
            end
          end
          S_CAPTURE: begin
            if (pix_write && (x_in == X_LAST) && (y_in == Y_LAST)) begin
              state  <= S_ISSUE;
              scan_x <= '0;
              scan_y <= '0;
            end
          end
          S_ISSUE: begin
            rd_addr_c_out  <= scan_c;
            rd_addr_w_out  <= nb_ok[1] ? scan_c - ONE_A : '0;
            rd_addr_nw_out <= nb_ok[2] ? scan_c - W_A - ONE_A : '0;
            rd_addr_n_out  <= nb_ok[3] ? scan_c - W_A : '0;
            rd_addr_ne_out <= nb_ok[4] ? scan_c - W_A + ONE_A : '0;
            wait_cnt       <= CNT_LOAD;
            state          <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt == '0) begin
              win_mask  <= rd_data_in & nb_ok;
              win_x     <= scan_x;
              win_y     <= scan_y;
              win_valid <= 1'b1;
              state     <= S_PRESENT;
            end else begin
              wait_cnt <= wait_cnt - CNT_W'(1);
            end
          end
          S_PRESENT: begin
            if (win.win_ready_in) begin
              win_valid <= 1'b0;
              if (scan_last) begin
                done_out <= 1'b1;
                busy_out <= 1'b0;
                state    <= S_IDLE;
              end else begin
                if (scan_x == X_LAST) begin
                  scan_x <= '0;
                  scan_y <= scan_y + 10'd1;
                end else begin
                  scan_x <= scan_x + 11'd1;
                end
                state <= S_ISSUE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ccl_scan_sequencer.sv
// Testbench for ccl_scan_sequencer at WIDTH=4, HEIGHT=3, RAM_LATENCY=2.
// A small frame-buffer RAM model answers the DUT's reads; expected windows
// and addresses come from a pixel-level model of the stored frame.
module tb_ccl_scan_sequencer;
  localparam int WIDTH       = 4;
  localparam int HEIGHT      = 3;
  localparam int RAM_LATENCY = 2;
  localparam int NPIX        = WIDTH * HEIGHT;
  localparam int ADDR_W      = $clog2(NPIX);
  localparam int SB_W        = 26;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic new_frame = 1'b0;
  logic abort = 1'b0;
  logic valid = 1'b0;
  logic mask = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic wr_en, wr_data, busy, done;
  logic [ADDR_W-1:0] wr_addr, rd_c, rd_w, rd_nw, rd_n, rd_ne;
  logic [4:0] rd_data;
  logic [2:0] dbg_state;

  ccl_scan_sequencer_if win_if();

  always #5 clk = ~clk;

  ccl_scan_sequencer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .RAM_LATENCY(RAM_LATENCY)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .new_frame_in(new_frame), .abort_in(abort),
    .x_in(x), .y_in(y), .mask_in(mask), .valid_in(valid),
    .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .rd_addr_c_out(rd_c), .rd_addr_w_out(rd_w), .rd_addr_nw_out(rd_nw),
    .rd_addr_n_out(rd_n), .rd_addr_ne_out(rd_ne), .rd_data_in(rd_data),
    .win(win_if), .busy_out(busy), .done_out(done), .dbg_state(dbg_state)
  );

  // Frame-buffer model: write on the clock, read data one register behind
  // the addresses so it is valid by the end of the WAIT period.
  logic mem [0:15];
  logic [4:0] rd_q = '0;
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= {mem[rd_ne], mem[rd_n], mem[rd_nw], mem[rd_w], mem[rd_c]};
  end
  assign rd_data = rd_q;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic px(input logic [NPIX-1:0] f, input int xx, input int yy);
    if (xx < 0 || xx >= WIDTH || yy < 0 || yy >= HEIGHT) return 1'b0;
    return f[yy*WIDTH + xx];
  endfunction

  function automatic logic [4:0] exp_win(input logic [NPIX-1:0] f, input int xx, input int yy);
    return {px(f, xx+1, yy-1), px(f, xx, yy-1), px(f, xx-1, yy-1), px(f, xx-1, yy), px(f, xx, yy)};
  endfunction

  function automatic int nb_addr(input int xx, input int yy, input int dx, input int dy);
    int nx, ny;
    nx = xx + dx;
    ny = yy + dy;
    if (nx < 0 || nx >= WIDTH || ny < 0) return 0;
    return ny*WIDTH + nx;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input int xx, input int yy, input logic m);
    @(negedge clk);
    new_frame = 1'b0;
    valid = v;
    x = 11'(xx);
    y = 10'(yy);
    mask = m;
  endtask

  task automatic capture(input logic [NPIX-1:0] f, input bit noisy);
    @(negedge clk);
    new_frame = 1'b1;
    valid = 1'b1; x = '0; y = '0; mask = 1'b1;
    #1 check("idle_no_write", 32'(wr_en), 0);
    for (int p = 0; p < NPIX; p++) begin
      if (p == 4) begin
        drive(1'b1, WIDTH, 0, 1'b1);
        #1 check("oor_x4_no_write", 32'(wr_en), 0);
      end
      if (noisy && $urandom_range(0, 2) == 0) begin
        drive(1'b0, $urandom_range(0, WIDTH-1), $urandom_range(0, HEIGHT-1), 1'b1);
        #1 check("bubble_no_write", 32'(wr_en), 0);
      end
      if (noisy && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) drive(1'b1, WIDTH + $urandom_range(0, 3), $urandom_range(0, HEIGHT-1), 1'b1);
        else drive(1'b1, $urandom_range(0, WIDTH-1), HEIGHT + $urandom_range(0, 3), 1'b1);
        #1 check("oor_no_write", 32'(wr_en), 0);
      end
      drive(1'b1, p % WIDTH, p / WIDTH, f[p]);
      #1;
      check("wr_en", 32'(wr_en), 1);
      check("wr_addr", 32'(wr_addr), 32'(p));
      check("wr_data", 32'(wr_data), 32'(f[p]));
    end
  endtask

  // mode 0: ready high; mode 1: ready low for 10 cycles at (3,0);
  // mode 2: random ready, random new_frame and stray pixels during the scan.
  task automatic run_scan(input logic [NPIX-1:0] f, input int mode);
    int cyc, last_acc, accepts, dones, bp_left, stall, ex, ey;
    bit finished, rdy;
    logic [SB_W-1:0] e;
    cyc = 0; last_acc = 0; accepts = 0; dones = 0; bp_left = 10; stall = 0;
    finished = 1'b0;
    exp_q.delete();
    for (int yy = 0; yy < HEIGHT; yy++)
      for (int xx = 0; xx < WIDTH; xx++)
        exp_q.push_back({11'(xx), 10'(yy), exp_win(f, xx, yy)});
    while (!finished && cyc < 600) begin
      drive(mode == 2 ? 1'(($urandom_range(0, 1))) : 1'b0,
            $urandom_range(0, WIDTH-1), $urandom_range(0, HEIGHT-1), 1'b1);
      cyc++;
      rdy = 1'b1;
      if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
      if (exp_q.size() > 0) e = exp_q[0];
      if (mode == 1 && win_if.win_valid_out && exp_q.size() > 0 &&
          e[25:15] == 11'd3 && e[14:5] == 10'd0 && bp_left > 0) begin
        rdy = 1'b0;
        bp_left--;
      end
      win_if.win_ready_in = rdy;
      new_frame = (mode == 2 && exp_q.size() > 0) ? ($urandom_range(0, 4) == 0) : 1'b0;
      #1;
      check("scan_no_write", 32'(wr_en), 0);
      if (done) begin
        dones++;
        check("done_cycle", 32'(cyc), 32'(last_acc + 1));
        check("busy_at_done", 32'(busy), 0);
      end
      if (win_if.win_valid_out) begin
        if (exp_q.size() == 0) begin
          check("extra_window", 32'(win_if.win_valid_out), 0);
        end else begin
          ex = int'(e[25:15]);
          ey = int'(e[14:5]);
          check("win_x", 32'(win_if.win_x_out), 32'(ex));
          check("win_y", 32'(win_if.win_y_out), 32'(ey));
          check("win_mask", 32'(win_if.win_mask_out), 32'(e[4:0]));
          check("rd_addr_c", 32'(rd_c), 32'(nb_addr(ex, ey, 0, 0)));
          check("rd_addr_w", 32'(rd_w), 32'(nb_addr(ex, ey, -1, 0)));
          check("rd_addr_nw", 32'(rd_nw), 32'(nb_addr(ex, ey, -1, -1)));
          check("rd_addr_n", 32'(rd_n), 32'(nb_addr(ex, ey, 0, -1)));
          check("rd_addr_ne", 32'(rd_ne), 32'(nb_addr(ex, ey, 1, -1)));
          if (rdy) begin
            check("accept_spacing", 32'(cyc - last_acc), 32'(4 + stall));
            void'(exp_q.pop_front());
            accepts++;
            last_acc = cyc;
            stall = 0;
          end else begin
            stall++;
          end
        end
      end
      if (exp_q.size() == 0 && dones > 0) finished = 1'b1;
    end
    if (!finished) check("scan_timeout", 32'(finished), 1);
    check("accepts", 32'(accepts), 32'(NPIX));
    check("done_pulses", 32'(dones), 1);
    if (mode == 1) check("bp_hold_cycles", 32'(bp_left), 0);
    drive(1'b0, 0, 0, 1'b0);
    #1;
    check("done_width", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 32'({wr_en, wr_addr, wr_data, busy, done}), 0);
    check({tag, "_rd"}, 32'({rd_c, rd_w, rd_nw, rd_n, rd_ne}), 0);
    check({tag, "_win"}, 32'({win_if.win_valid_out, win_if.win_mask_out,
                              win_if.win_x_out, win_if.win_y_out}), 0);
  endtask

  // ---------------- main sequence ----------------
  logic [NPIX-1:0] f_dir;
  logic [NPIX-1:0] f_rnd;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 1'b1;
    win_if.win_ready_in = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("busy_after_reset", 32'(busy), 0);

    // Directed frame: mask only at (1,1) and (2,1).
    f_dir = '0;
    f_dir[5] = 1'b1;
    f_dir[6] = 1'b1;
    capture(f_dir, 1'b0);
    run_scan(f_dir, 0);

    // Same frame with (0,0) set, so address 0 reads back 1; backpressure at (3,0).
    capture(f_dir | NPIX'(1), 1'b0);
    run_scan(f_dir | NPIX'(1), 1);

    // Abort during WAIT.
    f_rnd = NPIX'($urandom());
    capture(f_rnd, 1'b1);
    drive(1'b0, 0, 0, 1'b0);
    win_if.win_ready_in = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    #1 check("busy_before_abort", 32'(busy), 1);
    drive(1'b1, 1, 1, 1'b1);
    abort = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(win_if.win_valid_out), 0);
    check("abort_no_write", 32'(wr_en), 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 0, 0, 1'b0);
      #1;
      check("abort_no_done", 32'(done), 0);
      check("abort_no_window", 32'(win_if.win_valid_out), 0);
    end

    // Asynchronous reset in the middle of a scan.
    f_rnd = NPIX'($urandom());
    capture(f_rnd, 1'b1);
    for (int i = 0; i < 9; i++) drive(1'b0, 0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("busy_after_release", 32'(busy), 0);
    capture(f_rnd, 1'b1);
    run_scan(f_rnd, 2);

    // Randomized frames.
    for (int k = 0; k < 3; k++) begin
      f_rnd = NPIX'($urandom());
      capture(f_rnd, 1'b1);
      run_scan(f_rnd, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
